// File: rtl/ifu_prefetch.sv
// Instruction fetch unit with a prefetch queue and pipelined in-order requests.
// Redirects flush queued entries; responses still in flight are dropped when they return.
module ifu_prefetch #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000),
  parameter int DEPTH = 4,
  parameter int MAX_OUT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [31:0]     mem_resp_data,
  input  logic            mem_resp_err,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic            out_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] q_pc [DEPTH];
  logic [31:0]     q_inst [DEPTH];
  logic [DEPTH-1:0] q_err;
  logic [DEPTH-1:0] q_filled;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW-1:0]   fill;
  logic [CW-1:0]   count;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop_cnt;
  logic            halted;

  logic issue;
  logic resp;
  logic pop;
  logic unused_bits;

  assign unused_bits = ^redirect_pc[1:0];

  assign mem_req_valid = !rst && !redirect_valid && !halted
                      && (inflight < CW'(MAX_OUT))
                      && (count < CW'(DEPTH));
  assign mem_req_addr  = fetch_pc;

  assign out_valid = !rst && q_filled[head] && !redirect_valid;
  assign out_pc    = rst ? '0 : q_pc[head];
  assign out_inst  = rst ? '0 : q_inst[head];
  assign out_err   = rst ? 1'b0 : q_err[head];

  assign issue = mem_req_valid && mem_req_ready;
  assign resp  = mem_resp_valid && (inflight != '0);
  assign pop   = out_valid && out_ready;

  // Queue, pointers and request accounting; redirect overrides issue and pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      fill     <= '0;
      count    <= '0;
      inflight <= '0;
      drop_cnt <= '0;
      halted   <= 1'b0;
      q_err    <= '0;
      q_filled <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_pc[i]   <= '0;
        q_inst[i] <= '0;
      end
    end else if (redirect_valid) begin
      head     <= '0;
      tail     <= '0;
      fill     <= '0;
      count    <= '0;
      halted   <= 1'b0;
      q_filled <= '0;
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      drop_cnt <= drop_cnt + inflight - CW'(resp);
      inflight <= inflight - CW'(resp);
    end else begin
      if (issue) begin
        q_pc[tail]     <= fetch_pc;
        q_filled[tail] <= 1'b0;
        tail           <= tail + PW'(1);
        fetch_pc       <= fetch_pc + XLEN'(4);
      end
      if (resp) begin
        if (drop_cnt != '0) begin
          drop_cnt <= drop_cnt - CW'(1);
        end else begin
          q_inst[fill]   <= mem_resp_data;
          q_err[fill]    <= mem_resp_err;
          q_filled[fill] <= 1'b1;
          fill           <= fill + PW'(1);
          if (mem_resp_err) halted <= 1'b1;
        end
      end
      if (pop) begin
        q_filled[head] <= 1'b0;
        head           <= head + PW'(1);
      end
      count    <= count + CW'(issue) - CW'(pop);
      inflight <= inflight + CW'(issue) - CW'(resp);
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: pipelined memory model with variable latency,
// scoreboard of accepted PCs checked at each IDU handshake, directed checks.
module tb_ifu_prefetch;

  localparam logic [31:0] RPC  = 32'h8000_0000;
  localparam logic [31:0] NONE = 32'h0000_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic        mem_resp_err = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_err;

  int tests = 0;
  int fails = 0;
  int npop = 0;
  int nacc = 0;
  int nerr = 0;
  int cyc = 0;
  int lat = 1;
  logic [31:0] err_addr = NONE;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr = RPC;

  ifu_prefetch dut (
    .clk(clk),
    .rst(rst),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data),
    .mem_resp_err(mem_resp_err),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .out_inst(out_inst),
    .out_err(out_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Memory: answers each accepted request lat cycles later, in order.
  always @(negedge clk) begin
    cyc++;
    mem_resp_valid = 1'b0;
    if (rst) begin
      pend.delete();
    end else begin
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = inst_of(pend[0].addr);
        mem_resp_err   = (pend[0].addr == err_addr);
        void'(pend.pop_front());
      end
      if (mem_req_valid && mem_req_ready)
        pend.push_back('{mem_req_addr, cyc + lat});
    end
  end

  // Scoreboard: every accepted PC must reach the IDU in order unless flushed.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst) begin
      exp_q.delete();
      exp_addr = RPC;
    end else if (redirect_valid) begin
      exp_q.delete();
      exp_addr = redirect_pc & ~32'h3;
    end else begin
      if (out_valid && out_ready) begin
        npop++;
        check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("out_pc", out_pc, e);
          check("out_inst", out_inst, inst_of(e));
          check("out_err", 32'(out_err), 32'(e == err_addr));
          if (out_err) nerr++;
        end
      end
      if (mem_req_valid && mem_req_ready) begin
        nacc++;
        check("req_addr", mem_req_addr, exp_addr);
        exp_q.push_back(exp_addr);
        exp_addr += 32'd4;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int p;
    int a;
    int a0;
    int e;

    // reset state
    step(2);
    #1;
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    rst = 1'b0;
    #1;
    check("first_req_valid", 32'(mem_req_valid), 32'd1);
    check("first_req_addr", mem_req_addr, RPC);

    // streaming at one instruction per cycle
    step(6);
    p = npop;
    step(10);
    check("throughput", 32'(npop - p), 32'd10);

    // IDU stall: queue fills to DEPTH and issue stops
    out_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0200;
    #1;
    check("redir_req_valid", 32'(mem_req_valid), 32'd0);
    check("redir_out_valid", 32'(out_valid), 32'd0);
    step(1);
    redirect_valid = 1'b0;
    a = nacc;
    step(20);
    check("stall_issues", 32'(nacc - a), 32'd4);
    check("stall_req_valid", 32'(mem_req_valid), 32'd0);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    check("stall_head_pc", out_pc, 32'h8000_0200);
    out_ready = 1'b1;
    p = npop;
    step(8);
    check("resume_flow", 32'(npop - p >= 4), 32'd1);

    // redirect with two requests in flight
    mem_req_ready = 1'b0;
    step(4);
    lat = 4;
    mem_req_ready = 1'b1;
    step(2);
    check("two_inflight_block", 32'(mem_req_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_1002;
    step(1);
    redirect_valid = 1'b0;
    lat = 1;
    for (int i = 0; i < 20 && !out_valid; i++) step(1);
    check("redir_wait", 32'(out_valid), 32'd1);
    check("redir_first_pc", out_pc, 32'h8000_1000);

    // access fault halts fetch until redirect
    err_addr = 32'h8000_0008;
    redirect_valid = 1'b1;
    redirect_pc = RPC;
    step(1);
    redirect_valid = 1'b0;
    e = nerr;
    a0 = nacc;
    step(12);
    a = nacc;
    step(5);
    check("halt_no_issue", 32'(nacc - a), 32'd0);
    check("halt_total_issued", 32'(nacc - a0), 32'd4);
    check("halt_req_valid", 32'(mem_req_valid), 32'd0);
    check("err_emitted", 32'(nerr - e), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0100;
    step(1);
    redirect_valid = 1'b0;
    err_addr = NONE;
    #1;
    check("halt_clr_valid", 32'(mem_req_valid), 32'd1);
    check("halt_clr_addr", mem_req_addr, 32'h8000_0100);

    // request stalled by memory, withdrawn by redirect
    step(3);
    mem_req_ready = 1'b0;
    #1;
    check("hold_c1_valid", 32'(mem_req_valid), 32'd1);
    check("hold_c1_addr", mem_req_addr, exp_addr);
    step(1);
    check("hold_c2_valid", 32'(mem_req_valid), 32'd1);
    check("hold_c2_addr", mem_req_addr, exp_addr);
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_2000;
    #1;
    check("hold_withdraw", 32'(mem_req_valid), 32'd0);
    step(1);
    redirect_valid = 1'b0;
    #1;
    check("hold_c3_valid", 32'(mem_req_valid), 32'd1);
    check("hold_c3_addr", mem_req_addr, 32'h8000_2000);
    step(1);
    mem_req_ready = 1'b1;
    step(4);

    // reset with three slots reserved and one request in flight
    out_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_3000;
    step(1);
    redirect_valid = 1'b0;
    step(3);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_req_valid", 32'(mem_req_valid), 32'd0);
    step(1);
    rst = 1'b0;
    #1;
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    check("post_rst_req_valid", 32'(mem_req_valid), 32'd1);
    check("post_rst_addr", mem_req_addr, RPC);
    out_ready = 1'b1;
    p = npop;
    step(10);
    check("post_rst_flow", 32'(npop - p >= 6), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
